// File: rtl/data_memory.sv
// data_memory: word-addressed doubleword store for the single-cycle datapath.
// Loads are combinational, so they complete in the cycle they are issued.
// Stores commit on the rising clock edge. Reset is synchronous and clears
// every word. If reset and a store arrive in the same cycle, reset wins.
module data_memory #(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 6,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRd,
    input  logic              memWr,
    input  logic [63:0]       dir,
    input  logic [DATA_W-1:0] dataWr,
    output logic [DATA_W-1:0] dataRd
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;

    // The upper address bits are dropped, so addresses alias modulo DEPTH.
    logic unused_dir_hi;

    assign idx           = dir[ADDR_W-1:0];
    assign unused_dir_hi = ^dir[63:ADDR_W];

    // Storage update: reset clears every word, otherwise a store writes the full word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWr) begin
            mem_q[idx] <= dataWr;
        end
    end

    // Combinational load. It returns the old word until a same-cycle store commits.
    always_comb begin
        dataRd = '0;
        if (memRd) begin
            dataRd = mem_q[idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory. Expected load values are queued when
// the stimulus is applied. Each one is popped and compared when dataRd is sampled.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        memRd;
    logic        memWr;
    logic [63:0] dir;
    logic [63:0] dataWr;
    logic [63:0] dataRd;

    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    data_memory #(.DATA_W(64), .ADDR_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .memRd  (memRd),
        .memWr  (memWr),
        .dir    (dir),
        .dataWr (dataWr),
        .dataRd (dataRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag);
        logic [63:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: observed=%h expected=<empty scoreboard>", tag, dataRd);
        end else begin
            exp = sb.pop_front();
            assert (dataRd === exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, dataRd, exp);
            end
        end
    endtask

    // Drive a store on the falling edge, then let it commit on the rising edge.
    task automatic write_word(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        memWr  = 1'b1;
        memRd  = 1'b0;
        dir    = a;
        dataWr = d;
        @(posedge clk);
        #1;
        memWr  = 1'b0;
    endtask

    // Combinational load with no clock edge involved.
    task automatic read_word(input logic [63:0] a, input logic [63:0] exp, input string tag);
        memRd = 1'b1;
        dir   = a;
        expect_val(exp);
        #1;
        check(tag);
    endtask

    initial begin
        reset  = 1'b1;
        memRd  = 1'b0;
        memWr  = 1'b0;
        dir    = '0;
        dataWr = '0;

        // 1: a single reset edge leaves all words at zero
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        read_word(64'd0,  64'h0, "rst_w0");
        read_word(64'd1,  64'h0, "rst_w1");
        read_word(64'd63, 64'h0, "rst_w63");

        // 2: two stores, and word 1 is not clobbered
        write_word(64'd1, 64'h3);
        write_word(64'd0, 64'h1FFF);
        read_word(64'd1, 64'h3,    "wr_w1");
        read_word(64'd0, 64'h1FFF, "wr_w0");

        // 3: memRd gates the output combinationally
        memRd = 1'b0;
        dir   = 64'd0;
        expect_val(64'h0);
        #1;
        check("rd_off");
        memRd = 1'b1;
        expect_val(64'h1FFF);
        #1;
        check("rd_on_comb");

        // A clock edge with memWr=0 holds memory
        @(negedge clk);
        memRd  = 1'b0;
        memWr  = 1'b0;
        dir    = 64'd1;
        dataWr = 64'hBAD0_BAD0;
        @(posedge clk);
        #1;
        read_word(64'd1, 64'h3, "hold_w1");

        // 4: read-during-write returns old data until the commit
        write_word(64'd5, 64'hA);
        @(negedge clk);
        memRd  = 1'b1;
        memWr  = 1'b1;
        dir    = 64'd5;
        dataWr = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_val(64'hA);
        #1;
        check("rdw_before");
        @(posedge clk);
        expect_val(64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        check("rdw_after");
        memWr = 1'b0;

        // 5: reset overrides a simultaneous store and erases all stored data
        @(negedge clk);
        reset  = 1'b1;
        memWr  = 1'b1;
        dataWr = 64'h55;
        dir    = 64'd2;
        memRd  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        memWr = 1'b0;
        read_word(64'd2, 64'h0, "rst_drop_w2");
        read_word(64'd0, 64'h0, "rst_clr_w0");
        read_word(64'd1, 64'h0, "rst_clr_w1");
        read_word(64'd5, 64'h0, "rst_clr_w5");

        // 6: addresses alias modulo DEPTH, and the top word is read back intact
        write_word(64'd64, 64'hDEAD);
        read_word(64'd0, 64'hDEAD, "alias_w0");
        write_word(64'd63, 64'h8000_0000_0000_0001);
        read_word(64'd63,  64'h8000_0000_0000_0001, "w63");
        read_word(64'd127, 64'h8000_0000_0000_0001, "alias_w63");
        read_word(64'hFFFF_FFFF_FFFF_FFC0, 64'hDEAD, "alias_hi_w0");

        memRd = 1'b0;
        expect_val(64'h0);
        #1;
        check("final_rd_off");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
